// File: rtl/sample_streamer.sv
// ---------------------------------------------------------------------------
// sample_streamer: walks the sample memory at a programmable rate and ships
// each 12-bit sample to an SPI DAC as a {CMD, sample} 16-bit frame.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sample_streamer #(
  parameter int         SIZE  = 32,
  parameter int         DIV_W = 16,
  parameter logic [3:0] CMD   = 4'b0011
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [DIV_W-1:0] divider,
  output logic             read,
  output logic [4:0]       address,
  input  logic [11:0]      sample,
  output logic             dac_cs_n,
  output logic             dac_sclk,
  output logic             dac_mosi,
  output logic             wrap,
  output logic             overrun
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_LOAD  = 3'd2;
  localparam logic [2:0] ST_SHIFT = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam logic [4:0] LAST_ADDR = 5'(SIZE - 1);

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [DIV_W-1:0] tick_cnt;
  logic [DIV_W-1:0] period_m1;
  logic             tick;
  logic [4:0]       bit_cnt;
  logic [15:0]      shreg;

  // A zero divider behaves like 1, i.e. a tick every cycle.
  assign period_m1 = (divider == '0) ? '0 : divider - DIV_W'(1);
  assign tick      = enable && (tick_cnt >= period_m1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
    end else if (!enable || tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (tick) state_nxt = ST_FETCH;
      ST_FETCH: state_nxt = ST_LOAD;
      ST_LOAD:  state_nxt = ST_SHIFT;
      ST_SHIFT: if (bit_cnt == 5'd31) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // bit_cnt[0] is the sclk phase; the shift happens at the end of each high phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg   <= '0;
      bit_cnt <= '0;
      address <= '0;
    end else begin
      case (state)
        ST_LOAD: begin
          shreg   <= {CMD, sample};
          bit_cnt <= '0;
        end
        ST_SHIFT: begin
          bit_cnt <= bit_cnt + 5'd1;
          if (bit_cnt[0]) shreg <= {shreg[14:0], 1'b0};
        end
        ST_DONE:  address <= (address == LAST_ADDR) ? 5'd0 : address + 5'd1;
        default:  ;
      endcase
    end
  end

  always_comb begin
    read     = (state == ST_FETCH);
    dac_cs_n = (state != ST_SHIFT);
    dac_sclk = (state == ST_SHIFT) && bit_cnt[0];
    dac_mosi = (state == ST_SHIFT) && shreg[15];
    wrap     = (state == ST_DONE) && (address == LAST_ADDR);
    overrun  = tick && (state != ST_IDLE);
  end

endmodule

`default_nettype wire

// File: tb/tb_sample_streamer.sv
// ---------------------------------------------------------------------------
// tb_sample_streamer: scoreboard bench for sample_streamer with a registered
// memory model and an SPI frame monitor.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_sample_streamer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [15:0] divider = 16'd40;
  logic        read;
  logic [4:0]  address;
  logic [11:0] sample = 12'h000;
  logic        dac_cs_n, dac_sclk, dac_mosi, wrap, overrun;

  sample_streamer dut (
    .clk(clk), .rst(rst), .enable(enable), .divider(divider),
    .read(read), .address(address), .sample(sample),
    .dac_cs_n(dac_cs_n), .dac_sclk(dac_sclk), .dac_mosi(dac_mosi),
    .wrap(wrap), .overrun(overrun)
  );

  always #5 clk = ~clk;

  logic [11:0] mem [32];
  always @(posedge clk) if (read) sample <= mem[address];

  int checks = 0;
  int failures = 0;

  // Scoreboard and monitor state
  logic [15:0] exp_q[$];
  int          read_times[$];
  logic [4:0]  exp_addr = 5'd0;
  int          cycle = 0;
  int          read_count = 0, frames_done = 0, wrap_count = 0, overrun_count = 0;
  int          rises = 0, cs_low = 0;
  logic [15:0] shift_in = 16'h0, last_frame = 16'h0;
  logic        prev_sclk = 1'b0, prev_cs = 1'b1;

  always @(posedge clk) cycle++;

  always @(negedge clk) begin
    if (rst) begin
      rises = 0; cs_low = 0; shift_in = 16'h0; prev_sclk = 1'b0; prev_cs = 1'b1;
    end else begin
      if (read) begin
        read_count++;
        read_times.push_back(cycle);
        checks++;
        if (address !== exp_addr) begin
          failures++;
          $display("FAIL read_addr: got %0d expected %0d", address, exp_addr);
        end
        exp_q.push_back({4'h3, mem[exp_addr]});
        exp_addr = (exp_addr == 5'd31) ? 5'd0 : exp_addr + 5'd1;
      end
      if (wrap) wrap_count++;
      if (overrun) overrun_count++;
      if (!dac_cs_n) begin
        cs_low++;
        if (dac_sclk && !prev_sclk) begin
          shift_in = {shift_in[14:0], dac_mosi};
          rises++;
        end
      end
      if (dac_cs_n && !prev_cs) begin
        checks++;
        if (rises != 16 || cs_low != 32) begin
          failures++;
          $display("FAIL frame_shape: rises=%0d cs_low=%0d expected 16/32", rises, cs_low);
        end
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL frame_data: got %h with nothing expected", shift_in);
        end else begin
          logic [15:0] e;
          e = exp_q.pop_front();
          if (shift_in !== e) begin
            failures++;
            $display("FAIL frame_data: got %h expected %h", shift_in, e);
          end
        end
        last_frame = shift_in;
        frames_done++;
        rises = 0; cs_low = 0; shift_in = 16'h0;
      end
      prev_sclk = dac_sclk;
      prev_cs   = dac_cs_n;
    end
  end

  task automatic apply_reset();
    @(posedge clk); #2 rst = 1'b1;
    exp_q.delete(); read_times.delete();
    exp_addr = 5'd0; read_count = 0; frames_done = 0; wrap_count = 0; overrun_count = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_frames(input int n, input int budget, output bit timed_out);
    int k = 0;
    while (frames_done < n && k < budget) begin @(negedge clk); k++; end
    timed_out = (frames_done < n);
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({read, dac_cs_n, dac_sclk, dac_mosi, wrap, overrun} !== 6'b010000 || address !== 5'd0) begin
      failures++;
      $display("FAIL reset_outputs: got rd=%b cs=%b sclk=%b mosi=%b wrap=%b ovr=%b addr=%0d",
               read, dac_cs_n, dac_sclk, dac_mosi, wrap, overrun, address);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single_frame();
    bit to;
    mem[0] = 12'hABC;
    divider = 16'd40; enable = 1'b1;
    wait_frames(1, 200, to);
    enable = 1'b0;
    checks++;
    if (to) begin failures++; $display("FAIL single_timeout: frames=%0d expected 1", frames_done); end
    repeat (3) @(negedge clk);
    checks++;
    if (last_frame !== 16'h3ABC) begin failures++; $display("FAIL single_data: got %h expected 3abc", last_frame); end
    checks++;
    if (address !== 5'd1 || read_count != 1) begin
      failures++;
      $display("FAIL single_addr: addr=%0d reads=%0d expected 1/1", address, read_count);
    end
  endtask

  task automatic test_wrap();
    bit to;
    apply_reset();
    divider = 16'd40; enable = 1'b1;
    wait_frames(32, 32 * 40 + 200, to);
    enable = 1'b0;
    checks++;
    if (to) begin failures++; $display("FAIL wrap_timeout: frames=%0d expected 32", frames_done); end
    repeat (3) @(negedge clk);
    checks++;
    if (wrap_count != 1 || address !== 5'd0) begin
      failures++;
      $display("FAIL wrap_pulse: wraps=%0d addr=%0d expected 1/0", wrap_count, address);
    end
    for (int i = 1; i < read_times.size(); i++) begin
      checks++;
      if (read_times[i] - read_times[i-1] != 40) begin
        failures++;
        $display("FAIL wrap_period: frame %0d spacing %0d expected 40", i, read_times[i] - read_times[i-1]);
      end
    end
  endtask

  task automatic test_overrun();
    bit to;
    apply_reset();
    divider = 16'd10; enable = 1'b1;
    wait_frames(3, 400, to);
    enable = 1'b0;
    checks++;
    if (to) begin failures++; $display("FAIL overrun_timeout: frames=%0d expected 3", frames_done); end
    repeat (3) @(negedge clk);
    checks++;
    if (overrun_count != 9) begin
      failures++;
      $display("FAIL overrun_count: got %0d expected 9", overrun_count);
    end
    for (int i = 1; i < read_times.size(); i++) begin
      checks++;
      if (read_times[i] - read_times[i-1] != 40) begin
        failures++;
        $display("FAIL overrun_period: frame %0d spacing %0d expected 40", i, read_times[i] - read_times[i-1]);
      end
    end
  endtask

  task automatic test_reset_mid_shift();
    bit to;
    int k = 0;
    divider = 16'd40; enable = 1'b1;
    while (rises < 7 && k < 200) begin @(negedge clk); k++; end
    checks++;
    if (rises < 7) begin failures++; $display("FAIL midreset_timeout: rises=%0d expected 7", rises); end
    @(posedge clk); #2 rst = 1'b1;
    #1;
    checks++;
    if (dac_cs_n !== 1'b1 || dac_sclk !== 1'b0 || address !== 5'd0 || read !== 1'b0) begin
      failures++;
      $display("FAIL midreset_outputs: cs=%b sclk=%b addr=%0d rd=%b expected 1/0/0/0",
               dac_cs_n, dac_sclk, address, read);
    end
    exp_q.delete(); read_times.delete();
    exp_addr = 5'd0; read_count = 0; frames_done = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_frames(1, 200, to);
    enable = 1'b0;
    checks++;
    if (to) begin failures++; $display("FAIL midreset_resume: frames=%0d expected 1", frames_done); end
    repeat (3) @(negedge clk);
    checks++;
    if (address !== 5'd1) begin failures++; $display("FAIL midreset_addr: got %0d expected 1", address); end
  endtask

  task automatic test_enable_drop();
    bit to;
    int k = 0;
    int reads0, frames0;
    reads0 = read_count; frames0 = frames_done;
    divider = 16'd40; enable = 1'b1;
    while (!read && k < 200) begin @(negedge clk); k++; end
    checks++;
    if (!read) begin failures++; $display("FAIL endrop_timeout: no read strobe"); end
    @(negedge clk);
    enable = 1'b0;
    wait_frames(frames0 + 1, 100, to);
    repeat (100) @(negedge clk);
    checks++;
    if (to || frames_done != frames0 + 1 || read_count != reads0 + 1) begin
      failures++;
      $display("FAIL endrop_frames: frames=%0d reads=%0d expected %0d/%0d",
               frames_done, read_count, frames0 + 1, reads0 + 1);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 12'($urandom);
    test_reset();
    test_single_frame();
    test_wrap();
    test_overrun();
    test_reset_mid_shift();
    test_enable_drop();
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL scoreboard_left: %0d frames unseen", exp_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
